// File: rtl/ifft8_stream_if.sv
// Streaming interface for ifft8_stream: frequency bins in, time-domain samples out.
// slave = the transform block, master = the producer/consumer around it.
interface ifft8_stream_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 out_last;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/ifft8_stream.sv
// Sequential 8-point radix-2 DIF inverse FFT: LOAD 8 bins, 3 in-place butterfly stages, UNLOAD in natural order.
// Define IFFT_SCALE_EN to halve every stage output (gain 1/8, true IDFT); otherwise gain 8 with wrap-around.
module ifft8_stream #(
    parameter int DW   = 16,
    parameter int TW_C = 11585
) (
    input  logic          clk,
    input  logic          rst,
    ifft8_stream_if.slave bus,
    output logic          busy
);
    localparam int PW = DW + 20;

    typedef enum logic [2:0] {LOAD, ST1, ST2, ST3, UNLOAD} state_e;
    typedef enum logic [1:0] {TW0, TWM1, TWM2, TWM3} tw_e;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef cplx_t [7:0] buf_t;

    typedef struct packed {
        cplx_t s;
        cplx_t d;
    } pair_t;

    localparam logic signed [PW-1:0] RND_HALF = PW'(8192);
    localparam logic signed [PW-1:0] TWC_W    = PW'(TW_C);

    // Q1.14 product back to DW bits: round half up, then wrap.
    function automatic logic signed [DW-1:0] rnd(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + RND_HALF) >>> 14;
        return r[DW-1:0];
    endfunction

    function automatic pair_t bfly(input cplx_t a, input cplx_t b, input tw_e tw);
        logic signed [DW:0]   sr, si, dr, di, nr;
        logic signed [PW-1:0] wr, wi;
        pair_t                o;
        sr = (DW+1)'(a.re) + (DW+1)'(b.re);
        si = (DW+1)'(a.im) + (DW+1)'(b.im);
        dr = (DW+1)'(a.re) - (DW+1)'(b.re);
        di = (DW+1)'(a.im) - (DW+1)'(b.im);
`ifdef IFFT_SCALE_EN
        sr = sr >>> 1;
        si = si >>> 1;
        dr = dr >>> 1;
        di = di >>> 1;
`endif
        wr     = PW'(dr);
        wi     = PW'(di);
        nr     = -di;
        o.s.re = sr[DW-1:0];
        o.s.im = si[DW-1:0];
        o.d.re = dr[DW-1:0];
        o.d.im = di[DW-1:0];
        case (tw)
            TWM1: begin
                o.d.re = rnd((wr - wi) * TWC_W);
                o.d.im = rnd((wr + wi) * TWC_W);
            end
            TWM2: begin
                o.d.re = nr[DW-1:0];
                o.d.im = dr[DW-1:0];
            end
            TWM3: begin
                o.d.re = rnd(-(wr + wi) * TWC_W);
                o.d.im = rnd((wr - wi) * TWC_W);
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] c);
        return {c[0], c[1], c[2]};
    endfunction

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    buf_t                 buf_q, buf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic signed [DW-1:0] out_re_q, out_re_d;
    logic signed [DW-1:0] out_im_q, out_im_d;
    pair_t                bf;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        bf          = '0;

        case (state_q)
            LOAD: begin
                if (in_ready_q && bus.in_valid) begin
                    buf_d[cnt_q] = {bus.in_re, bus.in_im};
                    cnt_d        = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = ST1;
                end
            end
            ST1: begin
                for (int k = 0; k < 4; k++) begin
                    bf                = bfly(buf_q[3'(k)], buf_q[3'(k + 4)], tw_e'(k[1:0]));
                    buf_d[3'(k)]      = bf.s;
                    buf_d[3'(k + 4)]  = bf.d;
                end
                state_d = ST2;
            end
            ST2: begin
                for (int g = 0; g < 2; g++) begin
                    for (int j = 0; j < 2; j++) begin
                        bf = bfly(buf_q[3'(4 * g + j)], buf_q[3'(4 * g + j + 2)],
                                  (j == 1) ? TWM2 : TW0);
                        buf_d[3'(4 * g + j)]     = bf.s;
                        buf_d[3'(4 * g + j + 2)] = bf.d;
                    end
                end
                state_d = ST3;
            end
            ST3: begin
                for (int k = 0; k < 4; k++) begin
                    bf                   = bfly(buf_q[3'(2 * k)], buf_q[3'(2 * k + 1)], TW0);
                    buf_d[3'(2 * k)]     = bf.s;
                    buf_d[3'(2 * k + 1)] = bf.d;
                end
                // x[0] sits at bit-reversed slot 0; present it straight from the final stage.
                state_d     = UNLOAD;
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                out_re_d    = buf_d[0].re;
                out_im_d    = buf_d[0].im;
            end
            UNLOAD: begin
                if (bus.out_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d     = LOAD;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_re_d   = buf_q[bitrev3(cnt_d)].re;
                        out_im_d   = buf_q[bitrev3(cnt_d)].im;
                        out_last_d = (cnt_d == 3'd7);
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        in_ready_d = (state_d == LOAD);
        busy_d     = !((state_d == LOAD) && (cnt_d == 3'd0));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    // NOTE: the sample buffer has no reset; a complete LOAD always rewrites it before it is read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ifft8_stream.sv
// Self-checking bench for ifft8_stream: random frames against a generic DIF reference model,
// plus fixed impulse/tone/DC frames, backpressure, input gaps and mid-frame reset.
`timescale 1ns/1ps
module tb_ifft8_stream;
    localparam int DW = 16;

`ifdef IFFT_SCALE_EN
    localparam int IMP_OUT = 100;
    localparam int DC_RE   = 10;
    localparam int DC_IM   = -5;
`else
    localparam int IMP_OUT = 800;
    localparam int DC_RE   = 80;
    localparam int DC_IM   = -40;
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;

    ifft8_stream_if #(.DW(DW)) bus ();

    ifft8_stream #(.DW(DW), .TW_C(11585)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int x_re[8], x_im[8];
    int got_re[8], got_im[8], got_last[8];
    int exp_re[8], exp_im[8];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint rq(input longint p);
        return (p + 64'sd8192) >>> 14;
    endfunction

    function automatic int wrap(input longint v);
        logic signed [DW-1:0] t;
        t = v[DW-1:0];
        return int'(t);
    endfunction

    // Generic radix-2 DIF IDFT: span 4,2,1 with twiddle exp(+j*2*pi*e/8) in Q14.
    task automatic model();
        longint br[8], bi[8];
        longint wr[4] = '{16384, 11585, 0, -11585};
        longint wi[4] = '{0, 11585, 16384, 11585};
        for (int i = 0; i < 8; i++) begin
            br[i] = x_re[i];
            bi[i] = x_im[i];
        end
        for (int span = 4; span >= 1; span = span / 2) begin
            for (int base = 0; base < 8; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    int p, q, e;
                    longint sr, si, dr, di;
                    p  = base + j;
                    q  = p + span;
                    e  = j * 4 / span;
                    sr = br[p] + br[q];
                    si = bi[p] + bi[q];
                    dr = br[p] - br[q];
                    di = bi[p] - bi[q];
`ifdef IFFT_SCALE_EN
                    sr = sr >>> 1;
                    si = si >>> 1;
                    dr = dr >>> 1;
                    di = di >>> 1;
`endif
                    br[p] = wrap(sr);
                    bi[p] = wrap(si);
                    br[q] = wrap(rq(dr * wr[e] - di * wi[e]));
                    bi[q] = wrap(rq(dr * wi[e] + di * wr[e]));
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            int r;
            r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            exp_re[n] = int'(br[r]);
            exp_im[n] = int'(bi[r]);
        end
    endtask

    task automatic set_all(input int re, input int im);
        for (int i = 0; i < 8; i++) begin
            x_re[i] = re;
            x_im[i] = im;
        end
    endtask

    task automatic set_bin(input int k, input int re, input int im);
        set_all(0, 0);
        x_re[k] = re;
        x_im[k] = im;
    endtask

    task automatic set_random();
        logic signed [DW-1:0] t;
        for (int i = 0; i < 8; i++) begin
            t = DW'($urandom);
            x_re[i] = int'(t);
            t = DW'($urandom);
            x_im[i] = int'(t);
        end
    endtask

    task automatic check_const(input string tag, input int er[8], input int ei[8]);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("%s/re%0d", tag, n), got_re[n], er[n]);
            check($sformatf("%s/im%0d", tag, n), got_im[n], ei[n]);
        end
    endtask

    // stall_mode: 0 = out_ready always 1, 1 = toggle every cycle, 2 = random.
    task automatic run_frame(input string tag, input int gap_pct, input int stall_mode, input bit chk_period);
        int sent = 0, rcvd = 0, cyc = 0, t8 = -1, first_ov = -1, last_cyc = -1;
        int ir_bad = 0, busy_bad = 0, stall_bad = 0;
        bit go, o_r, pre_ir, pre_ov, pre_last;
        logic signed [DW-1:0] pre_re, pre_im;
        while (rcvd < 8 && cyc < 400) begin
            go = (sent < 8) && ($urandom_range(99) >= gap_pct);
            if (go) begin
                bus.in_valid = 1'b1;
                bus.in_re    = DW'(x_re[sent]);
                bus.in_im    = DW'(x_im[sent]);
            end else begin
                // Junk beats while the block is busy must be ignored.
                bus.in_valid = (sent >= 8) ? 1'($urandom_range(1)) : 1'b0;
                bus.in_re    = DW'($urandom);
                bus.in_im    = DW'($urandom);
            end
            case (stall_mode)
                0:       o_r = 1'b1;
                1:       o_r = cyc[0];
                default: o_r = 1'($urandom_range(1));
            endcase
            bus.out_ready = o_r;
            pre_ir   = bus.in_ready;
            pre_ov   = bus.out_valid;
            pre_re   = bus.out_re;
            pre_im   = bus.out_im;
            pre_last = bus.out_last;
            @(posedge clk);
            #1;
            cyc++;
            if (go && pre_ir) begin
                sent++;
                if (sent == 8) t8 = cyc;
            end
            if (pre_ov && o_r) begin
                got_re[rcvd]   = int'(pre_re);
                got_im[rcvd]   = int'(pre_im);
                got_last[rcvd] = int'(pre_last);
                rcvd++;
                if (rcvd == 8) last_cyc = cyc;
            end else if (pre_ov && (bus.out_valid !== 1'b1 || bus.out_re !== pre_re ||
                                    bus.out_im !== pre_im || bus.out_last !== pre_last)) begin
                stall_bad++;
            end
            if (t8 >= 0 && first_ov < 0 && bus.out_valid === 1'b1) first_ov = cyc;
            if (t8 >= 0 && rcvd < 8 && bus.in_ready !== 1'b0) ir_bad++;
            if (sent > 0 && rcvd < 8 && busy !== 1'b1) busy_bad++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check({tag, "/handshakes"}, rcvd, 8);
        check({tag, "/latency"}, first_ov - t8, 3);
        check({tag, "/in_ready_low"}, ir_bad, 0);
        check({tag, "/busy_high"}, busy_bad, 0);
        check({tag, "/stall_hold"}, stall_bad, 0);
        check({tag, "/in_ready_back"}, bus.in_ready, 1);
        check({tag, "/out_valid_idle"}, bus.out_valid, 0);
        check({tag, "/busy_idle"}, busy, 0);
        if (chk_period) check({tag, "/period"}, last_cyc, 19);
        model();
        for (int n = 0; n < 8; n++) begin
            check($sformatf("%s/model_re%0d", tag, n), got_re[n], exp_re[n]);
            check($sformatf("%s/model_im%0d", tag, n), got_im[n], exp_im[n]);
            check($sformatf("%s/last%0d", tag, n), got_last[n], (n == 7) ? 1 : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int imp_re[8], zero8[8], dc_re[8], dc_im[8];
        for (int i = 0; i < 8; i++) begin
            imp_re[i] = IMP_OUT;
            zero8[i]  = 0;
            dc_re[i]  = 0;
            dc_im[i]  = 0;
        end
        dc_re[0] = DC_RE;
        dc_im[0] = DC_IM;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        #12;
        check("reset/in_ready", bus.in_ready, 1);
        check("reset/out_valid", bus.out_valid, 0);
        check("reset/out_last", bus.out_last, 0);
        check("reset/busy", busy, 0);
        check("reset/out_re", bus.out_re, 0);
        check("reset/out_im", bus.out_im, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        set_bin(0, 800, 0);
        run_frame("impulse", 0, 0, 1'b1);
        check_const("impulse", imp_re, zero8);

        set_bin(1, 800, 0);
        run_frame("tone", 0, 0, 1'b1);
`ifndef IFFT_SCALE_EN
        check_const("tone", '{800, 566, 0, -566, -800, -566, 0, 566},
                            '{0, 566, 800, 566, 0, -566, -800, -566});
`endif

        set_all(10, -5);
        run_frame("dc_stall", 0, 1, 1'b0);
        check_const("dc_stall", dc_re, dc_im);

        set_random();
        run_frame("rand_nogap", 0, 0, 1'b1);
        run_frame("rand_gap", 40, 0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            set_random();
            run_frame($sformatf("rand%0d", f), 30, 2, 1'b0);
        end

        // Reset while the block is in ST2 discards the frame.
        set_bin(3, 1234, -4321);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = DW'(x_re[i]);
            bus.in_im    = DW'(x_im[i]);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid/busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid/in_ready", bus.in_ready, 1);
        check("mid/out_valid", bus.out_valid, 0);
        check("mid/busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_bin(0, 800, 0);
        run_frame("post_reset", 0, 0, 1'b1);
        check_const("post_reset", imp_re, zero8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
